i2s_audio_tx: RTL and testbench
===============================

# i2s_audio_tx

Stereo audio output stage that drains left/right 32-bit samples from the two output FIFOs of the demodulator/filter chain and serialises them as a standard I2S stream to the board DAC. It is the reading end of the FIFO interface: it drives `rd_en` and consumes `dout`/`empty` of a first-word-fall-through `fifo`. It also generates its own bit clock and word clock, and converts fixed-point samples to saturated PCM.

## Interface
- `DATA_WIDTH`, 32: FIFO sample width, signed two's complement.
- `AUDIO_WIDTH`, 16: PCM bits per channel slot; frame is 2·AUDIO_WIDTH bits.
- `SHIFT`, 10: arithmetic right shift applied before saturation (fixed-point fraction bits).
- `BCLK_DIV`, 4: system clocks per bclk half-period; must be ≥1.
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `left_dout` in DATA_WIDTH: left FIFO head word; valid while `left_empty`=0.
- `left_empty` in 1: left FIFO empty.
- `left_rd_en` out 1: pop left FIFO.
- `right_dout` in DATA_WIDTH: right FIFO head word.
- `right_empty` in 1: right FIFO empty.
- `right_rd_en` out 1: pop right FIFO.
- `bclk` out 1: I2S bit clock.
- `lrclk` out 1: I2S word select; 0 = left, 1 = right.
- `sdata` out 1: I2S serial data, MSB first.
- `underrun` out 1: one-cycle pulse per frame sent as silence.

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, RUN.
- IDLE: `bclk`, `lrclk`, `sdata` held 0.
  - When `left_empty`=0 and `right_empty`=0, pulse both `rd_en` for one cycle.
  - Load both samples into shift registers, set `bit_cnt`=0 and `div_cnt`=0, then go to RUN.
- RUN:
  - `div_cnt` counts 0..BCLK_DIV-1. At terminal count `bclk` toggles.
  - A 1→0 toggle is a falling tick. Each falling tick advances `bit_cnt` modulo 2·AUDIO_WIDTH (W), and `sdata`/`lrclk` update.
- Slot mapping for `bit_cnt`=k:
  - k in 0..W-1: left bit W-1-k.
  - k in W..2W-1: right bit 2W-1-k.
  - `lrclk`=1 for k in W-1..2W-2, else 0. This gives standard I2S one-bclk lead.
- Frame boundary is the falling tick that wraps k from 2W-1 to 0.
  - Both FIFOs non-empty: pop both (`rd_en` high that cycle only) and load new samples.
  - Either FIFO empty: pop neither, so the pair stays aligned. Load 0 into both channels and pulse `underrun`.
  - The block never returns to IDLE except by reset.
- Conversion, per channel: `v = dout >>> SHIFT` (arithmetic).
  - If v > 2^(W-1)-1, output 2^(W-1)-1.
  - If v < -2^(W-1), output -2^(W-1).
  - Otherwise output v[W-1:0].
- `rd_en` is never asserted while the corresponding `empty`=1.

## Timing
- `bclk` period = 2·BCLK_DIV clocks.
- Frame = 2W bclk periods = 4·W·BCLK_DIV clocks (256 with defaults).
- IDLE→RUN start:
  - The `rd_en` pulse occurs in the first cycle both FIFOs show non-empty.
  - `sdata` presents left MSB from the next cycle.
  - First `bclk` rise is BCLK_DIV clocks after entering RUN.
- `sdata` and `lrclk` change only on the clock edge of a falling tick, i.e. they are stable around each `bclk` rise.
- The `rd_en` pulse and the `underrun` pulse coincide with the frame-boundary falling tick.
- Reset mid-frame: outputs go to 0 immediately (async). The partial frame is discarded and no FIFO pop occurs.

## Structure
- Package `audio_pkg`:
  - constants AUDIO_WIDTH_DEF, QUANT_SHIFT_DEF;
  - `state_t` enum {IDLE, RUN};
  - function `sat_pcm(value, shift)`.
- One sub-module, `bclk_gen`: the divider producing `bclk` plus one-cycle `rise_tick`/`fall_tick` strobes, with enable and synchronous clear.
- The top contains the FSM, `bit_cnt`, shift registers and FIFO handshake.

## Test plan
- Reset release with both FIFOs empty for 1000 clocks → `bclk`/`lrclk`/`sdata`/`rd_en` stay 0, no `underrun`.
- Push L=0x0000_0400, R=0xFFFF_FC00 → one pop pair. Serialised left word is 0x0001 and right word is 0xFFFF (decoded at `bclk` rises, MSB first, `lrclk` leading by one bit).
- Push L=0x7FFF_FFFF, R=0x8000_0000 → left 0x7FFF, right 0x8000 (saturation).
- Push 3 pairs, then stop → 3 frames carry data. The 4th frame is all zeros with one `underrun` pulse at its boundary, and no `rd_en` while empty.
- Left FIFO has 2 entries, right has 1 → second boundary is an underrun and neither FIFO pops. Refill right → left/right pairing preserved.
- Assert `reset` mid-right-slot → outputs 0 within the same cycle, no pop. After release, restart from IDLE on the next available pair.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the I2S audio output stage.
// Holds the channel defaults, the FSM state type and the PCM saturation helper.
package audio_pkg;

    localparam int AUDIO_WIDTH_DEF = 16;
    localparam int QUANT_SHIFT_DEF = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Arithmetic shift, then clamp to the signed range of a width-bit PCM word.
    function automatic logic signed [63:0] sat_pcm(
        input logic signed [63:0] value,
        input int                 shift,
        input int                 width = AUDIO_WIDTH_DEF
    );
        logic signed [63:0] v_s;
        logic signed [63:0] hi_s;
        logic signed [63:0] lo_s;
        v_s  = value >>> shift;
        hi_s = (64'sd1 <<< (width - 32'sd1)) - 64'sd1;
        lo_s = -(64'sd1 <<< (width - 32'sd1));
        if (v_s > hi_s) begin
            sat_pcm = hi_s;
        end else if (v_s < lo_s) begin
            sat_pcm = lo_s;
        end else begin
            sat_pcm = v_s;
        end
    endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider: toggles bclk every DIV enabled clocks and flags the
// cycle whose closing edge produces a rising or falling bclk transition.
module bclk_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic             bclk_q;
    logic             bclk_d;
    logic             tc_s;

    assign tc_s = en && !clr && (div_cnt_q == TERM);

    // Next-state for the divider counter and the bit clock.
    always_comb begin
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        if (clr) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
        end else if (en) begin
            if (tc_s) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
                bclk_d    = bclk_q;
            end
        end else begin
            div_cnt_d = div_cnt_q;
            bclk_d    = bclk_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk      = bclk_q;
    assign rise_tick = tc_s && !bclk_q;
    assign fall_tick = tc_s && bclk_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: pops left/right sample pairs from two FWFT FIFOs,
// saturates them to PCM and shifts them out MSB first with one-bit lrclk lead.
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int AUDIO_WIDTH = AUDIO_WIDTH_DEF,
    parameter int SHIFT       = QUANT_SHIFT_DEF,
    parameter int BCLK_DIV    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] left_dout,
    input  logic                  left_empty,
    output logic                  left_rd_en,
    input  logic [DATA_WIDTH-1:0] right_dout,
    input  logic                  right_empty,
    output logic                  right_rd_en,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun
);

    localparam int FRAME_W = 2 * AUDIO_WIDTH;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LR_FIRST = CNT_W'(AUDIO_WIDTH - 1);
    localparam logic [CNT_W-1:0] LR_LAST  = CNT_W'(FRAME_W - 2);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 sdata_q, sdata_d;
    logic                 lrclk_q, lrclk_d;
    logic                 pop_s;
    logic                 underrun_s;
    logic                 both_avail_s;
    logic                 fall_tick_s;
    logic                 rise_tick_unused;
    logic [AUDIO_WIDTH-1:0] left_pcm_s;
    logic [AUDIO_WIDTH-1:0] right_pcm_s;

    assign left_pcm_s  = AUDIO_WIDTH'(sat_pcm(64'(signed'(left_dout)), SHIFT, AUDIO_WIDTH));
    assign right_pcm_s = AUDIO_WIDTH'(sat_pcm(64'(signed'(right_dout)), SHIFT, AUDIO_WIDTH));

    // Gated by reset so no pop can be requested while the block is held in reset.
    assign both_avail_s = reset && !left_empty && !right_empty;

    bclk_gen #(
        .DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clock),
        .rst_n     (reset),
        .en        (state_q == RUN),
        .clr       (state_q == IDLE),
        .bclk      (bclk),
        .rise_tick (rise_tick_unused),
        .fall_tick (fall_tick_s)
    );

    // FSM next-state, bit position, frame shift register and FIFO handshake.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        sdata_d    = sdata_q;
        lrclk_d    = lrclk_q;
        pop_s      = 1'b0;
        underrun_s = 1'b0;
        case (state_q)
            IDLE: begin
                sdata_d = 1'b0;
                lrclk_d = 1'b0;
                if (both_avail_s) begin
                    pop_s     = 1'b1;
                    frame_d   = {left_pcm_s, right_pcm_s};
                    sdata_d   = left_pcm_s[AUDIO_WIDTH-1];
                    bit_cnt_d = '0;
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (fall_tick_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        // Frame boundary: take a full pair or send silence, never half a pair.
                        bit_cnt_d = '0;
                        if (both_avail_s) begin
                            pop_s   = 1'b1;
                            frame_d = {left_pcm_s, right_pcm_s};
                        end else begin
                            underrun_s = 1'b1;
                            frame_d    = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        frame_d   = frame_q << 1;
                    end
                    sdata_d = frame_d[FRAME_W-1];
                    lrclk_d = (bit_cnt_d >= LR_FIRST) && (bit_cnt_d <= LR_LAST);
                end else begin
                    bit_cnt_d = bit_cnt_q;
                    frame_d   = frame_q;
                end
            end
            default: begin
                state_d = IDLE;
                sdata_d = 1'b0;
                lrclk_d = 1'b0;
            end
        endcase
    end

    // State and serial output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            sdata_q   <= 1'b0;
            lrclk_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            sdata_q   <= sdata_d;
            lrclk_q   <= lrclk_d;
        end
    end

    assign sdata       = sdata_q;
    assign lrclk       = lrclk_q;
    assign left_rd_en  = pop_s;
    assign right_rd_en = pop_s;
    assign underrun    = underrun_s;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: queue-based FWFT FIFOs, a frame-level reference
// model and an I2S decoder that reassembles words at bclk rises.
module tb_i2s_audio_tx;

    localparam int DIV   = 4;
    localparam int AW    = 16;
    localparam int SH    = 10;
    localparam int FRAME = 4 * AW * DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] left_dout = 32'd0;
    logic [31:0] right_dout = 32'd0;
    logic        left_empty = 1'b1;
    logic        right_empty = 1'b1;
    logic        left_rd_en, right_rd_en, bclk, lrclk, sdata, underrun;

    i2s_audio_tx dut (
        .clock       (clock),
        .reset       (reset),
        .left_dout   (left_dout),
        .left_empty  (left_empty),
        .left_rd_en  (left_rd_en),
        .right_dout  (right_dout),
        .right_empty (right_empty),
        .right_rd_en (right_rd_en),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    logic [31:0] lq[$];
    logic [31:0] rq[$];
    logic [15:0] expq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference conversion: floor-divide by 2^SH, then clamp to 16-bit signed.
    function automatic logic [15:0] pcm(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        v = v >>> SH;
        if (v > 64'sd32767) v = 64'sd32767;
        else if (v < -64'sd32768) v = -64'sd32768;
        return 16'(v);
    endfunction

    task automatic refresh();
        left_empty  = (lq.size() == 0);
        right_empty = (rq.size() == 0);
        if (lq.size() > 0) left_dout = lq[0]; else left_dout = 32'd0;
        if (rq.size() > 0) right_dout = rq[0]; else right_dout = 32'd0;
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        lq.push_back(l);
        rq.push_back(r);
        refresh();
    endtask

    // FIFO model: a pop requested before an edge takes effect just after it.
    logic lp, rp;
    always @(posedge clock) begin
        lp = left_rd_en;
        rp = right_rd_en;
        #1;
        if (lp) begin
            check("left_pop_nonempty", 64'(lq.size() != 0), 64'd1);
            if (lq.size() != 0) void'(lq.pop_front());
        end
        if (rp) begin
            check("right_pop_nonempty", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) void'(rq.pop_front());
        end
        refresh();
    end

    // Reference model and decoder, evaluated mid-cycle.
    logic        running = 1'b0;
    int          e = 0;
    logic        exp_pop, exp_und, first_msb;
    logic        prev_bclk = 1'b0, prev_lr = 1'b0, cur_ch = 1'b0, ch;
    logic [15:0] word = 16'd0, tmp;
    int          nbits = 0;
    int          words_seen = 0;

    always @(negedge clock) begin
        exp_pop = 1'b0;
        exp_und = 1'b0;
        if (!reset) begin
            running = 1'b0;
            expq.delete();
            nbits   = 0;
            prev_lr = 1'b0;
            cur_ch  = 1'b0;
        end else if (!running) begin
            if (lq.size() > 0 && rq.size() > 0) begin
                exp_pop = 1'b1;
                running = 1'b1;
                e       = 0;
                tmp       = pcm(lq[0]);
                first_msb = tmp[15];
                expq.push_back(tmp);
                expq.push_back(pcm(rq[0]));
            end
        end else begin
            e++;
            if (e % FRAME == 0) begin
                if (lq.size() > 0 && rq.size() > 0) begin
                    exp_pop = 1'b1;
                    expq.push_back(pcm(lq[0]));
                    expq.push_back(pcm(rq[0]));
                end else begin
                    exp_und = 1'b1;
                    expq.push_back(16'd0);
                    expq.push_back(16'd0);
                end
            end
        end
        check("left_rd_en", 64'(left_rd_en), 64'(exp_pop));
        check("right_rd_en", 64'(right_rd_en), 64'(exp_pop));
        check("underrun", 64'(underrun), 64'(exp_und));
        if (!running || e == 0) begin
            check("idle_pins", 64'({bclk, lrclk, sdata}), 64'd0);
        end else begin
            check("bclk_phase", 64'(bclk), 64'(((e - 1) / DIV) % 2));
            if (e == 1) check("first_msb", 64'(sdata), 64'(first_msb));
        end
        if (running && bclk && !prev_bclk) begin
            ch = prev_lr;
            if (nbits > 0 && ch != cur_ch) begin
                words_seen++;
                check("word_len", 64'(nbits), 64'(AW));
                check("word_avail", 64'(expq.size() > 0), 64'd1);
                if (expq.size() > 0)
                    check(cur_ch ? "right_word" : "left_word", 64'(word), 64'(expq.pop_front()));
                nbits = 0;
            end
            cur_ch  = ch;
            word    = {word[14:0], sdata};
            nbits++;
            prev_lr = lrclk;
        end
        prev_bclk = bclk;
    end

    initial begin
        refresh();
        repeat (5) @(posedge clock);
        #2;
        check("reset_outputs", 64'({bclk, lrclk, sdata, left_rd_en, right_rd_en, underrun}), 64'd0);
        reset = 1'b1;
        repeat (1000) @(posedge clock);

        // Unit-ish values: 1024 >> 10 = 1, -1024 >> 10 = -1.
        #2 push(32'h0000_0400, 32'hFFFF_FC00);
        repeat (2 * FRAME) @(posedge clock);

        #2 push(32'h7FFF_FFFF, 32'h8000_0000);
        repeat (2 * FRAME) @(posedge clock);

        // Three pairs then starvation.
        #2;
        for (int i = 0; i < 3; i++) push($urandom, $urandom_range(0, 32'h00FF_FFFF));
        repeat (5 * FRAME) @(posedge clock);

        // Unbalanced FIFOs: two left, one right, then refill right.
        #2;
        lq.push_back(32'h0012_3400);
        lq.push_back(32'hFFF0_0000);
        rq.push_back(32'h0000_7C00);
        refresh();
        repeat (3 * FRAME) @(posedge clock);
        #2;
        rq.push_back(32'h0765_4321);
        refresh();
        repeat (3 * FRAME) @(posedge clock);

        // Random traffic with random gaps.
        for (int i = 0; i < 6; i++) begin
            #2;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                push($urandom ^ ($urandom_range(0, 1) ? 32'hFFC0_0000 : 32'h0000_0000),
                     $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000);
            repeat ($urandom_range(30, 300)) @(posedge clock);
        end

        // Reset in the middle of a right slot.
        #2 push(32'h0001_0000, 32'hFFFF_0000);
        for (int i = 0; i < 4 * FRAME && !(running && (e % FRAME) == 160); i++) @(posedge clock);
        check("reach_right_slot", 64'(running && (e % FRAME) == 160), 64'd1);
        #2;
        check("pre_reset_lrclk", 64'(lrclk), 64'd1);
        push(32'h0000_2C00, 32'hFFFF_D400);
        reset = 1'b0;
        #1;
        check("reset_async", 64'({bclk, lrclk, sdata, left_rd_en, right_rd_en, underrun}), 64'd0);
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        repeat (3 * FRAME) @(posedge clock);

        #2;
        check("pending_words", 64'(expq.size() <= 2), 64'd1);
        check("words_decoded", 64'(words_seen >= 30), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
